// File: rtl/counter.sv
// ============================================================================
//  Module      : counter
//  Description : WIDTH-bit up/down counter with synchronous clear, load and a
//                registered overflow pulse. Define COUNTER_SATURATE_EN to hold
//                at the bound instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic             down,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] c_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_overflow;

  logic             w_at_bound;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_next_en;

  // An enabled step from the bound in the current direction is the wrap point.
  assign w_at_bound = down ? (r_count == '0) : (r_count == c_MAX);
  assign w_step     = down ? (r_count - c_ONE) : (r_count + c_ONE);

`ifdef COUNTER_SATURATE_EN
  assign w_next_en = w_at_bound ? r_count : w_step;
`else
  assign w_next_en = w_step;
`endif

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (load) begin
      r_count    <= load_val;
      r_overflow <= 1'b0;
    end else if (en) begin
      r_count    <= w_next_en;
      r_overflow <= w_at_bound;
    end else begin
      r_overflow <= 1'b0;
    end
  end

  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_counter.sv
// ============================================================================
//  Module      : tb_counter
//  Description : Scoreboard bench driving WIDTH=4, 8 and 20 counters in lockstep.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter;

  logic        clk = 1'b0;
  logic        rst, clr, en, load, down;
  logic [31:0] lv;

  logic [3:0]  c4;
  logic [7:0]  c8;
  logic [19:0] c20;
  logic        ov4, ov8, ov20;

  int checks = 0;
  int errors = 0;

  logic [32:0] q4[$];
  logic [32:0] q8[$];
  logic [32:0] q20[$];
  logic [31:0] m4, m8, m20;

  always #5 clk = ~clk;

  counter #(.WIDTH(4)) u_c4 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .load(load), .down(down),
    .load_val(lv[3:0]), .count(c4), .overflow(ov4)
  );
  counter #(.WIDTH(8)) u_c8 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .load(load), .down(down),
    .load_val(lv[7:0]), .count(c8), .overflow(ov8)
  );
  counter #(.WIDTH(20)) u_c20 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .load(load), .down(down),
    .load_val(lv[19:0]), .count(c20), .overflow(ov20)
  );

  // Reference behaviour: returns {overflow, count} after one rising edge.
  function automatic logic [32:0] model(input int w, input logic [31:0] cur,
                                        input logic r, input logic c, input logic l,
                                        input logic e, input logic d, input logic [31:0] v);
    logic [31:0] mask;
    logic        sat;
    mask = (32'h1 << w) - 32'h1;
`ifdef COUNTER_SATURATE_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
    if (r || c)  return {1'b0, 32'h0};
    if (l)       return {1'b0, v & mask};
    if (!e)      return {1'b0, cur};
    if (!d) begin
      if (cur == mask) return sat ? {1'b1, mask} : {1'b1, 32'h0};
      return {1'b0, cur + 32'h1};
    end
    if (cur == 32'h0) return sat ? {1'b1, 32'h0} : {1'b1, mask};
    return {1'b0, cur - 32'h1};
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed ovf=%0b cnt=%h expected ovf=%0b cnt=%h",
             tag, obs[32], obs[31:0], exp[32], exp[31:0]);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic l, input logic e,
                      input logic d, input logic [31:0] v);
    logic [32:0] res;
    rst = r; clr = c; load = l; en = e; down = d; lv = v;
    res = model(4,  m4,  r, c, l, e, d, v); m4  = res[31:0]; q4.push_back(res);
    res = model(8,  m8,  r, c, l, e, d, v); m8  = res[31:0]; q8.push_back(res);
    res = model(20, m20, r, c, l, e, d, v); m20 = res[31:0]; q20.push_back(res);
    @(posedge clk);
    #1;
    chk("w4",  {ov4,  32'(c4)},  q4.pop_front());
    chk("w8",  {ov8,  32'(c8)},  q8.pop_front());
    chk("w20", {ov20, 32'(c20)}, q20.pop_front());
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0; load = 1'b0; down = 1'b0; lv = '0;
    m4 = '0; m8 = '0; m20 = '0;
    @(negedge clk);

    // Reset for two cycles with other inputs active, then count up from 0.
    step(1, 0, 1, 1, 0, 32'hFFFF_FFFF);
    step(1, 0, 0, 1, 0, 32'h0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 32'h0);

    // Load near top, step up through wrap.
    step(0, 0, 1, 0, 0, 32'hFFFF_FFFE);
    step(0, 0, 0, 1, 0, 32'h0);
    step(0, 0, 0, 1, 0, 32'h0);
    step(0, 0, 0, 1, 0, 32'h0);

    // From 0 count down: wrap to max with pulse, then max-1 without.
    step(0, 1, 0, 0, 0, 32'h0);
    step(0, 0, 0, 1, 1, 32'h0);
    step(0, 0, 0, 1, 1, 32'h0);

    // Priority: clr beats load and en; rst beats load.
    step(0, 0, 1, 0, 0, 32'h55);
    step(0, 1, 1, 1, 0, 32'hAA);
    step(0, 0, 1, 0, 0, 32'h55);
    step(1, 0, 1, 1, 0, 32'hAA);
    // Load beats en; hold cycle keeps count with overflow low.
    step(0, 0, 1, 1, 1, 32'h1234_5);
    step(0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 1, 32'h0);

    // Attempted steps past the top bound, then direction flips immediately.
    step(0, 0, 1, 0, 0, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 32'h0);
    step(0, 0, 0, 1, 1, 32'h0);
    step(0, 0, 0, 1, 0, 32'h0);
    step(0, 0, 0, 1, 1, 32'h0);

    // Mixed random traffic.
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 14) == 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), $urandom);

    // Top three bits of the 8-bit counter advance once every 32 steps.
    step(0, 1, 0, 0, 0, 32'h0);
    for (int k = 0; k < 255; k++) begin
      step(0, 0, 0, 1, 0, 32'h0);
      checks++;
      assert (c8[7:5] === 3'(((k + 1) >> 5) & 7)) else begin
        errors++;
        $error("FAIL msb8 step=%0d observed=%0d expected=%0d", k, c8[7:5], ((k + 1) >> 5) & 7);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the counter width in bits (integer >= 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port clr, input, 1 bit: synchronous clear request.
REQ-005 SHALL have port en, input, 1 bit: count enable.
REQ-006 SHALL have port load, input, 1 bit: synchronous load request.
REQ-007 SHALL have port down, input, 1 bit: direction; 0 = increment, 1 = decrement.
REQ-008 SHALL have port load_val, input, WIDTH bits: value taken on load; narrower connections zero-extend.
REQ-009 SHALL have port count, output, WIDTH bits: current count, driven directly from the register.
REQ-010 SHALL have port overflow, output, 1 bit: registered wrap/terminal pulse.
REQ-011 SHALL accept ordered (positional) connection in exactly the sequence clk, rst, clr, en, load, down, load_val, count, overflow.

Function
REQ-012 SHALL evaluate per rising edge with priority rst > clr > load > en; lower-priority requests in the same cycle are ignored.
REQ-013 SHALL on clr set count = 0 and overflow = 0.
REQ-014 SHALL on load (no rst/clr) set count = load_val[WIDTH-1:0] and overflow = 0.
REQ-015 SHALL on en with down=0 set count = count+1 modulo 2^WIDTH.
REQ-016 SHALL on en with down=1 set count = count-1 modulo 2^WIDTH.
REQ-017 SHALL hold count when en, load, clr and rst are all 0, and drive overflow = 0 in that cycle.
REQ-018 SHALL assert overflow for exactly one cycle, the cycle after an enabled step from 2^WIDTH-1 upward or from 0 downward; otherwise deassert it.
REQ-019 SHALL permit down to change on any cycle; a change takes effect on the next enabled step with no additional latency.
REQ-020 SHALL, with en held at 1 and down at 0, make count[WIDTH-1:WIDTH-3] cycle through 0..7, each value lasting 2^(WIDTH-3) cycles.

Reset
REQ-021 SHALL on rst=1 at a rising edge set count = 0 and overflow = 0, regardless of all other inputs.
REQ-022 SHALL resume normal operation on the first edge after rst is deasserted; no state survives reset.

Configuration
REQ-023 SHALL recognise macro COUNTER_SATURATE_EN.
REQ-024 SHALL without COUNTER_SATURATE_EN wrap as stated in REQ-015/016.
REQ-025 SHALL with COUNTER_SATURATE_EN hold count at 2^WIDTH-1 when incrementing, or at 0 when decrementing, instead of wrapping.
REQ-026 SHALL with COUNTER_SATURATE_EN assert overflow for every enabled step attempted past the bound.

Structure
REQ-027 SHALL use no shared package; WIDTH is the only configuration constant.
REQ-028 SHALL be a single module with no sub-modules; no sub-module is natural at this size.

Verification
REQ-029 WIDTH=20, rst=1 for 2 cycles, then en=1, down=0 -> count 0,1,2,... one step per cycle; overflow=0.
REQ-030 WIDTH=4, load=1 with load_val=4'hE, then en=1 for 2 cycles -> count E,F,0; overflow=1 only in the cycle count becomes 0.
REQ-031 WIDTH=4, count=0, en=1, down=1 -> count F, overflow=1 for one cycle; then E with overflow=0.
REQ-032 WIDTH=8, clr=1, load=1 and en=1 together at count=8'h55 -> count=0 next cycle; rst=1 with clr=0 -> count=0.
REQ-033 WIDTH=4, COUNTER_SATURATE_EN defined, count=F, en=1, down=0 for 3 cycles -> count stays F; overflow=1 on each of the 3 cycles.
REQ-034 WIDTH=20, en=1 for 2^20 cycles from 0 -> count[19:17] visits 0..7, each held for 131072 cycles; overflow=1 once, at wrap.
